// File: rtl/mux_nto1_rr.sv
// rtl/mux_nto1_rr.sv - registered N:1 valid/ready multiplexer with fixed-select and round-robin modes
module mux_nto1_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          mode,
    input  logic [$clog2(CHANNELS)-1:0]   sel,
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
    input  logic [CHANNELS-1:0]           in_valid,
    output logic [CHANNELS-1:0]           in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(CHANNELS)-1:0]   out_chan,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          sel_err
);

    localparam int SEL_W = $clog2(CHANNELS);

    // Channel count and last index in widths matching the index arithmetic
    localparam logic [SEL_W:0]   CHAN_CNT = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] CHAN_LAST = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0]    ptr;
    logic [CHANNELS-1:0] grant;
    logic                rr_found;
    logic [SEL_W:0]      rr_sum;
    logic                sel_in_range;
    logic                load;
    logic                xfer;
    logic [SEL_W-1:0]    pick_idx;
    logic [WIDTH-1:0]    pick_data;
    logic [SEL_W-1:0]    ptr_next;

    // sel can exceed the channel count only when CHANNELS is not a power of two
    assign sel_in_range = ({1'b0, sel} < CHAN_CNT);

    // Output register can take a word when empty or being drained this cycle
    assign load = !out_valid || out_ready;

    // Grant: explicit select in mode 0, first valid channel at or after ptr in mode 1
    always_comb begin
        grant    = '0;
        rr_found = 1'b0;
        rr_sum   = '0;
        if (!mode) begin
            if (sel_in_range) begin
                grant[sel] = in_valid[sel];
            end
        end else begin
            for (int off = 0; off < CHANNELS; off++) begin
                rr_sum = {1'b0, ptr} + (SEL_W+1)'(off);
                if (rr_sum >= CHAN_CNT) begin
                    rr_sum = rr_sum - CHAN_CNT;
                end
                if (!rr_found && in_valid[rr_sum[SEL_W-1:0]]) begin
                    grant[rr_sum[SEL_W-1:0]] = 1'b1;
                    rr_found                 = 1'b1;
                end
            end
        end
    end

    // Ready is suppressed during reset and while a held word is stalled
    assign in_ready = {CHANNELS{reset_n && load}} & grant;

    // Grant only rises on a valid channel, so any ready bit means a transfer
    assign xfer = |in_ready;

    // Encode the one-hot grant into an index and pick that channel's word
    always_comb begin
        pick_idx  = '0;
        pick_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                pick_idx  = SEL_W'(i);
                pick_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves just past the served channel, wrapping at the last one
    assign ptr_next = (pick_idx == CHAN_LAST) ? '0 : pick_idx + 1'b1;

    // Output register, round-robin pointer and select-range flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= !mode && !sel_in_range;
            if (xfer) begin
                out_data  <= pick_data;
                out_chan  <= pick_idx;
                out_valid <= 1'b1;
                if (mode) begin
                    ptr <= ptr_next;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mux_nto1_rr.md
# mux_nto1_rr

Parametrised, registered N:1 multiplexer with valid/ready handshake on every input channel and on the output. It selects one input channel either by an explicit select (fixed mode) or by round-robin arbitration, then registers the chosen word for downstream. It is the general channel-count, data-width successor to the team's 4:1 behavioural mux and sits between multiple producers and a single consumer.

## Interface
- `WIDTH`, 8: data width per channel, ≥1.
- `CHANNELS`, 4: number of input channels, ≥2; need not be a power of two.
- `SEL_W` is a derived localparam, not overridable: `$clog2(CHANNELS)`.

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `mode`  in  1  0 = fixed select via `sel`; 1 = round-robin.
- `sel`  in  SEL_W  channel index, used in mode 0 only.
- `in_data`  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  CHANNELS  per-channel valid.
- `in_ready`  out  CHANNELS  per-channel ready; at most one bit high; combinational.
- `out_data`  out  WIDTH  registered selected word.
- `out_chan`  out  SEL_W  registered index of the channel that supplied `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.
- `sel_err`  out  1  registered flag: `sel` was out of range in the previous cycle.

## Operation
- Output register is one entry deep. `load = !out_valid || out_ready`.
- Grant vector `grant[CHANNELS-1:0]` is combinational and at most one-hot.
  - Mode 0: `grant[sel] = in_valid[sel]` when `sel < CHANNELS`. Otherwise grant is all zero.
  - Mode 1: scan channels starting at pointer `ptr` and wrapping modulo CHANNELS. Grant the first channel with `in_valid` high.
- `in_ready[i] = reset_n && load && grant[i]`. A transfer occurs on channel i when `in_valid[i] && in_ready[i]`.
- On a transfer from channel k:
  - `out_data <= in_data[k]`, `out_chan <= k`, `out_valid <= 1`.
  - Mode 1 only: `ptr <= (k == CHANNELS-1) ? 0 : k+1`.
- When `out_valid && out_ready` and there is no transfer, `out_valid <= 0`. `out_data` and `out_chan` keep their last value.
- When `out_valid && !out_ready`:
  - `out_data`, `out_chan` and `out_valid` hold.
  - All `in_ready` bits are 0.
- Simultaneous drain and transfer in the same cycle: the new word is loaded and `out_valid` stays 1. This gives full throughput.
- `ptr` is not modified in mode 0 and is retained across mode changes. `mode` and `sel` are sampled every cycle; a change affects the very next grant.
- `sel_err <= (mode == 0) && (sel >= CHANNELS)`. It is updated every cycle regardless of `load`. It can only be 1 when CHANNELS is not a power of two.
- No state machine beyond `ptr` and the output register. `ptr` width is SEL_W and its value is always < CHANNELS.

## Timing
- Reset (`reset_n` = 0 at a rising edge):
  - `out_valid` = 0, `out_data` = 0, `out_chan` = 0, `ptr` = 0, `sel_err` = 0.
  - `in_ready` is forced to 0 combinationally while `reset_n` is low.
- Reset mid-operation discards any held output word and takes priority over a simultaneous transfer. No partial state survives.
- Latency: a word accepted at edge n appears on `out_data` with `out_valid` = 1 after edge n.
- Throughput: one word per cycle while `out_ready` = 1 and some granted channel is valid.
- Round-robin fairness: with all channels continuously valid and `out_ready` = 1, each channel is served exactly once every CHANNELS cycles.
- Output stability: `out_data` and `out_chan` change only at an edge where a transfer occurs.

## Test plan
- **Reset:** hold `reset_n` = 0 for 2 cycles with `in_valid` = 4'b1111 and `out_ready` = 1. Require `in_ready` = 0000, `out_valid` = 0, `out_data` = 8'h00 and `out_chan` = 0 throughout.
- **Fixed mode, defaults:** data ch0..3 = A5, 3C, FF, 01, all valid, `out_ready` = 1, `sel` stepping 0,1,2,3 on successive cycles. Require `out_data` = A5, 3C, FF, 01 and `out_chan` = 0..3, each one cycle later.
- **Round-robin:** `mode` = 1 with all valid. Require `out_chan` = 0,1,2,3,0,1. Then drive only ch1 and ch3 valid. Require the sequence to alternate 1,3,1,3 with no idle cycles.
- **Backpressure:** a word 5A is held with `out_ready` = 0 for 3 cycles. Require `out_data` = 5A stable and `in_ready` = 0000. Raise `out_ready`. Require the next granted word loaded on the same edge the held word drains, with `out_valid` staying 1.
- **Out-of-range select:** CHANNELS = 3, `mode` = 0, `sel` = 3, all valid. Require `in_ready` = 000, no transfer, and `sel_err` = 1 one cycle later. Then `sel` = 2: require `sel_err` returns to 0 the next cycle and ch2 is transferred.
- **Reset mid-transfer:** `out_valid` = 1, `out_ready` = 0, `mode` = 1, `ptr` = 2; pulse `reset_n` low for 1 cycle. Require `out_valid` = 0 after the edge, and the first round-robin grant with all valid is ch0.
